// File: rtl/uart_rx_if.sv
// uart_rx_if: CPU-side byte handshake between the UART receiver and its peripheral logic
//   data, rdy, frame_err, overrun : receiver -> CPU (master drives)
//   rdy_clr                       : CPU -> receiver, clears rdy and overrun
interface uart_rx_if #(parameter int DATA_BITS = 8);
  logic [DATA_BITS-1:0] data;
  logic rdy;
  logic rdy_clr;
  logic frame_err;
  logic overrun;
  modport master(output data, rdy, frame_err, overrun, input rdy_clr);
  modport slave(input data, rdy, frame_err, overrun, output rdy_clr);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver on a 16x oversample strobe with ready/clear handshake and error flags
//   clk_50m  : system clock
//   rst_n    : asynchronous active-low reset
//   rxclk_en : one-clock 16x oversample strobe
//   rx       : asynchronous serial line, idles high
//   bus      : data/rdy/frame_err/overrun out, rdy_clr in
module uart_rx #(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic       clk_50m,
  input logic       rst_n,
  input logic       rxclk_en,
  input logic       rx,
  uart_rx_if.master bus
);
  localparam int IW = DATA_BITS > 1 ? $clog2(DATA_BITS) : 1;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
  state_t               state;
  logic [SYNC_STAGES-1:0] sync;
  logic [3:0]           cnt;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 rx_s;
  logic                 last_bit;
  assign rx_s     = sync[SYNC_STAGES-1];
  assign last_bit = bit_idx == IW'(DATA_BITS - 1);
  always_ff @(posedge clk_50m or negedge rst_n)
    if (!rst_n) begin
      sync          <= '1;
      state         <= IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      shift         <= '0;
      bus.data      <= '0;
      bus.rdy       <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.overrun   <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], rx};
      // a completing good frame below overrides this clear
      if (bus.rdy_clr) begin
        bus.rdy     <= 1'b0;
        bus.overrun <= 1'b0;
      end
      if (rxclk_en)
        case (state)
          IDLE: if (!rx_s) begin
            state <= START;
            cnt   <= '0;
          end
          START: begin
            cnt <= cnt + 4'd1;
            if (cnt == 4'd7) begin
              state   <= rx_s ? IDLE : DATA;
              cnt     <= '0;
              bit_idx <= '0;
            end
          end
          DATA: begin
            cnt <= cnt + 4'd1;
            if (cnt == 4'd15) begin
              shift[bit_idx] <= rx_s;
              bit_idx        <= last_bit ? '0 : bit_idx + IW'(1);
              state          <= last_bit ? STOP : DATA;
            end
          end
          STOP: begin
            cnt <= cnt + 4'd1;
            if (cnt == 4'd15) begin
              if (rx_s) begin
                bus.data      <= shift;
                bus.rdy       <= 1'b1;
                bus.frame_err <= 1'b0;
                if (bus.rdy && !bus.rdy_clr) bus.overrun <= 1'b1;
                state <= IDLE;
              end else begin
                bus.frame_err <= 1'b1;
                state         <= WAIT_HIGH;
              end
            end
          end
          WAIT_HIGH: state <= rx_s ? IDLE : WAIT_HIGH;
          default: state <= IDLE;
        endcase
    end
endmodule
